addsub_acc: RTL and testbench
=============================

Name: addsub_acc

Overview:
Multi-lane, registered, signed fixed-point adder/subtractor/accumulator for the LSTM datapath. It is the successor to the combinational adder-subtractor used by the activation-function units. It adds width and lane parametrisation, optional saturation, per-lane accumulators for dot-product and gate summation, and a valid/ready handshake so it can sit between pipelined multiplier arrays and activation units.

Parameters:
WIDTH, 32, bits per lane (signed two's complement)
LANES, 4, number of independent parallel lanes
SAT, 1, 1 = saturate results to the WIDTH range; 0 = wrap modulo 2^WIDTH

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
i_valid  input  1  input beat valid
o_ready  output  1  block can accept an input beat this cycle
i_a  input  LANES*WIDTH  operand A, lane k at bits [k*WIDTH +: WIDTH]
i_b  input  LANES*WIDTH  operand B, same packing; ignored in accumulate modes
i_mode  input  2  00 = A-B, 01 = A+B, 10 = acc+A, 11 = acc-A
i_first  input  1  accumulate modes only: treat the prior accumulator value as 0
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts the output beat
o  output  LANES*WIDTH  result, same packing as inputs
o_sat  output  LANES  per-lane flag: this beat's result was saturated (SAT=1) or overflowed (SAT=0)
o_sat_sticky  output  LANES  per-lane sticky flag: saturation/overflow since the last i_first or reset

Behaviour:
- Reset (rst=1 at a clock edge): o_valid=0, o=0, o_sat=0, o_sat_sticky=0, all accumulators=0. Reset overrides any simultaneous accept and aborts an accumulation in progress.
- o_ready = !o_valid || i_ready. This is combinational; there is no combinational path from i_valid to o_ready.
- Accept condition: i_valid && o_ready. Latency is 1 cycle; on accept, o, o_sat and o_valid=1 are registered.
- If o_valid && i_ready and there is no accept that cycle: o_valid goes to 0 and o holds its last value.
- If o_valid && !i_ready: o, o_sat and o_valid hold, and no input is accepted. Full throughput is one beat per cycle while i_ready=1.
- Arithmetic: compute per lane in WIDTH+1 bits with sign extension. Overflow occurs when the result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=1: clamp to the nearest bound.
  - SAT=0: truncate to WIDTH bits.
  - In both cases o_sat[k]=1 for that beat.
- Modes 00/01: o[k] = A-B or A+B. Accumulators are unchanged.
- Modes 10/11: base = i_first ? 0 : acc[k]. Result = base ± A[k] under the rules above; acc[k] and o[k] both receive the result.
  - Accumulators update only on accept, never during a stall.
  - Beats in modes 00/01 may be interleaved between accumulate beats without disturbing acc.
- o_sat_sticky[k]:
  - On an accepted beat with i_first=1 in modes 10/11, it is set to that beat's o_sat[k].
  - On any other accepted beat, it becomes sticky OR o_sat[k].
  - It holds otherwise.
- Back-to-back accumulate beats use the value updated on the previous edge. There is no bubble and no forwarding hazard, because acc is a register.
- i_first in modes 00/01 has no effect.
- Lanes are fully independent; carries never cross lanes.

Decomposition:
- Shared package: mode encodings (MODE_SUB=2'b00, MODE_ADD=2'b01, MODE_ACC_ADD=2'b10, MODE_ACC_SUB=2'b11).
- Shared package: a saturation helper (function returning the clamped value and an overflow bit, given a WIDTH+1 sum).
- One natural sub-module: addsub_lane, one lane's combinational add/sub, saturation and overflow detect. It is instantiated LANES times in a generate loop.
- The top level holds the handshake, output register, accumulators and sticky flags.

Test Plan:
1. WIDTH=8, LANES=2, SAT=1; mode 01 with lane0 100+50 and lane1 -100+-50, i_ready=1. One cycle later: o lanes = 127 and -128, o_sat=2'b11, o_valid=1.
2. Mode 00 with lane0 20-30 and lane1 5-5. Response: o lanes = -10 and 0, o_sat=0; accumulators remain 0 (check with a following mode 10, A=0, i_first=0 beat giving 0).
3. Accumulate sequence, lane0 A = 10, 20, 30 (first beat i_first=1, mode 10), then mode 11 with A=15. Outputs 10, 30, 60, 45 on consecutive cycles with no bubbles.
4. Backpressure: hold i_ready=0 for 3 cycles while i_valid=1. o_ready=0, o is stable, acc unchanged; on i_ready=1 the stalled beat is accepted exactly once (acc advances by A once).
5. SAT=0, WIDTH=8: mode 10 with i_first=1 and A=100, then A=100. Second output is -56 (wrapped), o_sat[0]=1, o_sat_sticky[0]=1. The next i_first=1 beat with A=1 clears sticky to 0.
6. Mid-accumulation reset: acc lane0=60, assert rst together with i_valid. Next cycle o_valid=0, o=0, flags=0. A mode 10 beat with i_first=0 and A=5 then outputs 5.

Source files
------------

// File: rtl/addsub_acc_pkg.sv
// Shared definitions for the multi-lane add/sub/accumulate datapath:
// operation encodings and the range-clamp helper used by every lane.
package addsub_acc_pkg;

  typedef enum logic [1:0] {
    MODE_SUB     = 2'b00,
    MODE_ADD     = 2'b01,
    MODE_ACC_ADD = 2'b10,
    MODE_ACC_SUB = 2'b11
  } mode_e;

  // Widest lane supported; lanes must be strictly narrower than this.
  localparam int MAX_W = 64;

  typedef logic signed [MAX_W:0] wide_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } sat_res_t;

  // sum is a sign-extended (w+1)-bit result; val holds the clamped value when
  // sat is set, otherwise the raw sum whose low w bits are the wrapped result.
  function automatic sat_res_t sat_clamp(input wide_t sum, input int w, input logic sat);
    wide_t    hi;
    wide_t    lo;
    sat_res_t res;
    hi      = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo      = ~hi;
    res.ovf = (sum > hi) || (sum < lo);
    res.val = sum[MAX_W-1:0];
    if (sat && (sum > hi)) begin
      res.val = hi[MAX_W-1:0];
    end else if (sat && (sum < lo)) begin
      res.val = lo[MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/addsub_acc_lane.sv
// One lane: signed lhs +/- rhs in WIDTH+1 bits, then clamp or wrap to WIDTH.
// Purely combinational; overflow flag reports any out-of-range result.
module addsub_lane
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SAT   = 1
) (
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic [WIDTH:0] lhs_x;
  logic [WIDTH:0] rhs_x;
  logic [WIDTH:0] sum;
  sat_res_t       sr;
  logic           unused_hi;

  always_comb begin
    lhs_x = {lhs[WIDTH-1], lhs};
    rhs_x = {rhs[WIDTH-1], rhs};
    // The exact result always fits in WIDTH+1 bits, so plain modular math is safe.
    sum   = sub ? (lhs_x - rhs_x) : (lhs_x + rhs_x);
    sr    = sat_clamp(wide_t'({{(MAX_W - WIDTH){sum[WIDTH]}}, sum}), WIDTH, SAT != 0);
    res   = sr.val[WIDTH-1:0];
    ovf   = sr.ovf;
  end

  assign unused_hi = ^sr.val[MAX_W-1:WIDTH];

endmodule

// File: rtl/addsub_acc.sv
// Registered multi-lane signed add/sub with per-lane accumulators and sticky
// overflow flags; one-cycle latency, valid/ready with a single output register.
module addsub_acc
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*WIDTH-1:0] i_a,
  input  logic [LANES*WIDTH-1:0] i_b,
  input  logic [1:0]             i_mode,
  input  logic                   i_first,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o,
  output logic [LANES-1:0]       o_sat,
  output logic [LANES-1:0]       o_sat_sticky
);

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  vec_t             a_v, b_v, lhs, rhs, res;
  vec_t             o_q, o_d, acc_q, acc_d;
  logic [LANES-1:0] ovf;
  logic [LANES-1:0] o_sat_q, o_sat_d;
  logic [LANES-1:0] sticky_q, sticky_d;
  logic             o_valid_q, o_valid_d;
  logic             accept, acc_mode, sub;

  assign a_v = i_a;
  assign b_v = i_b;

  always_comb begin
    acc_mode = (i_mode == MODE_ACC_ADD) || (i_mode == MODE_ACC_SUB);
    sub      = (i_mode == MODE_SUB) || (i_mode == MODE_ACC_SUB);
    lhs      = a_v;
    rhs      = b_v;
    if (acc_mode) begin
      // Accumulate: acc (or zero on a first beat) is the left operand, A the right.
      for (int k = 0; k < LANES; k++) begin
        lhs[k] = i_first ? '0 : acc_q[k];
        rhs[k] = a_v[k];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    addsub_lane #(
      .WIDTH(WIDTH),
      .SAT  (SAT)
    ) u_lane (
      .lhs(lhs[k]),
      .rhs(rhs[k]),
      .sub(sub),
      .res(res[k]),
      .ovf(ovf[k])
    );
  end

  assign o_ready = !o_valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  always_comb begin
    o_d       = o_q;
    o_sat_d   = o_sat_q;
    o_valid_d = o_valid_q;
    acc_d     = acc_q;
    sticky_d  = sticky_q;
    if (accept) begin
      o_d       = res;
      o_sat_d   = ovf;
      o_valid_d = 1'b1;
      if (acc_mode) begin
        acc_d = res;
      end
      sticky_d = (acc_mode && i_first) ? ovf : (sticky_q | ovf);
    end else if (i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= '0;
      o_sat_q   <= '0;
      o_valid_q <= 1'b0;
      acc_q     <= '0;
      sticky_q  <= '0;
    end else begin
      o_q       <= o_d;
      o_sat_q   <= o_sat_d;
      o_valid_q <= o_valid_d;
      acc_q     <= acc_d;
      sticky_q  <= sticky_d;
    end
  end

  assign o            = o_q;
  assign o_sat        = o_sat_q;
  assign o_valid      = o_valid_q;
  assign o_sat_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_acc.sv
// Bench for addsub_acc: a saturating and a wrapping instance share stimulus and
// are compared every cycle against an integer-arithmetic transaction model.
module tb_addsub_acc;
  import addsub_acc_pkg::*;

  localparam int W = 8;
  localparam int L = 2;

  logic           clk = 1'b0;
  logic           rst, i_valid, i_first, i_ready;
  logic [1:0]     i_mode;
  logic [L*W-1:0] i_a, i_b;
  logic           o_ready_s, o_valid_s, o_ready_w, o_valid_w;
  logic [L*W-1:0] o_s, o_w;
  logic [L-1:0]   sat_s, sat_w, stk_s, stk_w;

  always #5 clk = ~clk;

  addsub_acc #(.WIDTH(W), .LANES(L), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_s),
    .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .i_first(i_first),
    .o_valid(o_valid_s), .i_ready(i_ready), .o(o_s),
    .o_sat(sat_s), .o_sat_sticky(stk_s)
  );

  addsub_acc #(.WIDTH(W), .LANES(L), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_w),
    .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .i_first(i_first),
    .o_valid(o_valid_w), .i_ready(i_ready), .o(o_w),
    .o_sat(sat_w), .o_sat_sticky(stk_w)
  );

  int checks = 0;
  int passes = 0;

  // Model state; index 0 = saturating instance, 1 = wrapping instance.
  bit     m_valid;
  int     m_o[2][L];
  int     m_acc[2][L];
  bit     m_sat[2][L];
  bit     m_stk[2][L];
  int     a_in[L];
  int     b_in[L];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void lane_op(input int lhs, input int rhs, input bit sub,
                                  input bit sat, output int r, output bit ovf);
    int s;
    s   = sub ? lhs - rhs : lhs + rhs;
    ovf = (s > 127) || (s < -128);
    if (!ovf)     r = s;
    else if (sat) r = (s > 127) ? 127 : -128;
    else          r = ((s + 384) % 256) - 128;
  endfunction

  task automatic model_edge();
    bit ready;
    bit accm, sub, ov;
    int lhs, rhs, r;
    ready = !m_valid || i_ready;
    if (rst) begin
      m_valid = 0;
      for (int v = 0; v < 2; v++)
        for (int k = 0; k < L; k++) begin
          m_o[v][k] = 0; m_acc[v][k] = 0; m_sat[v][k] = 0; m_stk[v][k] = 0;
        end
    end else if (i_valid && ready) begin
      accm = (i_mode == 2'b10) || (i_mode == 2'b11);
      sub  = (i_mode == 2'b00) || (i_mode == 2'b11);
      for (int v = 0; v < 2; v++)
        for (int k = 0; k < L; k++) begin
          lhs = accm ? (i_first ? 0 : m_acc[v][k]) : a_in[k];
          rhs = accm ? a_in[k] : b_in[k];
          lane_op(lhs, rhs, sub, v == 0, r, ov);
          m_o[v][k]  = r;
          m_sat[v][k] = ov;
          if (accm) m_acc[v][k] = r;
          m_stk[v][k] = (accm && i_first) ? ov : (m_stk[v][k] | ov);
        end
      m_valid = 1;
    end else if (i_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("o_valid_sat", {31'b0, o_valid_s}, {31'b0, m_valid});
    check("o_valid_wrap", {31'b0, o_valid_w}, {31'b0, m_valid});
    for (int k = 0; k < L; k++) begin
      check($sformatf("o_sat_lane%0d", k), $signed(o_s[k*W +: W]), m_o[0][k]);
      check($sformatf("o_wrap_lane%0d", k), $signed(o_w[k*W +: W]), m_o[1][k]);
      check($sformatf("flag_sat_lane%0d", k), {31'b0, sat_s[k]}, {31'b0, m_sat[0][k]});
      check($sformatf("flag_wrap_lane%0d", k), {31'b0, sat_w[k]}, {31'b0, m_sat[1][k]});
      check($sformatf("sticky_sat_lane%0d", k), {31'b0, stk_s[k]}, {31'b0, m_stk[0][k]});
      check($sformatf("sticky_wrap_lane%0d", k), {31'b0, stk_w[k]}, {31'b0, m_stk[1][k]});
    end
  endtask

  // Inputs are already set; check o_ready, step the model and the clock, compare.
  task automatic cycle();
    for (int k = 0; k < L; k++) begin
      i_a[k*W +: W] = W'(a_in[k]);
      i_b[k*W +: W] = W'(b_in[k]);
    end
    #1;
    check("o_ready_sat", {31'b0, o_ready_s}, {31'b0, (!m_valid || i_ready)});
    check("o_ready_wrap", {31'b0, o_ready_w}, {31'b0, (!m_valid || i_ready)});
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic beat(input bit v, input bit [1:0] md, input bit f,
                      input int a0, input int a1, input int b0, input int b1,
                      input bit rdy);
    i_valid = v; i_mode = md; i_first = f; i_ready = rdy;
    a_in[0] = a0; a_in[1] = a1; b_in[0] = b0; b_in[1] = b1;
    cycle();
  endtask

  initial begin
    rst = 1; i_valid = 0; i_mode = 2'b00; i_first = 0; i_ready = 1;
    i_a = '0; i_b = '0;
    m_valid = 0;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < L; k++) begin
        m_o[v][k] = 0; m_acc[v][k] = 0; m_sat[v][k] = 0; m_stk[v][k] = 0;
      end
    for (int k = 0; k < L; k++) begin a_in[k] = 0; b_in[k] = 0; end
    @(posedge clk);
    #1;
    beat(0, 2'b00, 0, 0, 0, 0, 0, 1);
    rst = 0;
    check("reset_o", {16'b0, o_s}, 32'sd0);

    // Saturating add in both directions.
    beat(1, 2'b01, 0, 100, -100, 50, -50, 1);
    check("t1_lane0", $signed(o_s[7:0]), 127);
    check("t1_lane1", $signed(o_s[15:8]), -128);
    check("t1_sat", {30'b0, sat_s}, 32'sd3);

    // Subtract, then show acc untouched.
    beat(1, 2'b00, 0, 20, 5, 30, 5, 1);
    check("t2_lane0", $signed(o_s[7:0]), -10);
    beat(1, 2'b10, 0, 0, 0, 0, 0, 1);
    check("t2_acc_zero", $signed(o_s[7:0]), 0);

    // Back-to-back accumulation.
    beat(1, 2'b10, 1, 10, 3, 0, 0, 1);
    beat(1, 2'b10, 0, 20, -7, 0, 0, 1);
    beat(1, 2'b10, 0, 30, 1, 0, 0, 1);
    check("t3_sum60", $signed(o_s[7:0]), 60);
    beat(1, 2'b11, 0, 15, 2, 0, 0, 1);
    check("t3_sub45", $signed(o_s[7:0]), 45);

    // Backpressure: this beat is held for three stalled cycles then taken once.
    beat(1, 2'b10, 0, 7, 1, 0, 0, 0);
    beat(1, 2'b10, 0, 7, 1, 0, 0, 0);
    beat(1, 2'b10, 0, 7, 1, 0, 0, 0);
    check("t4_stall_hold", $signed(o_s[7:0]), 45);
    beat(1, 2'b10, 0, 7, 1, 0, 0, 1);
    check("t4_once", $signed(o_s[7:0]), 52);
    beat(0, 2'b10, 0, 0, 0, 0, 0, 1);
    beat(1, 2'b10, 0, 0, 0, 0, 0, 1);
    check("t4_acc", $signed(o_s[7:0]), 52);

    // Wrapping overflow and sticky clear on a first beat.
    beat(1, 2'b10, 1, 100, 0, 0, 0, 1);
    beat(1, 2'b10, 0, 100, 0, 0, 0, 1);
    check("t5_wrap", $signed(o_w[7:0]), -56);
    check("t5_sticky", {31'b0, stk_w[0]}, 32'sd1);
    beat(1, 2'b01, 0, 0, 0, 0, 0, 1);
    beat(1, 2'b10, 1, 1, 0, 0, 0, 1);
    check("t5_clear", {31'b0, stk_w[0]}, 32'sd0);

    // Reset in the middle of an accumulation.
    beat(1, 2'b10, 1, 10, 0, 0, 0, 1);
    beat(1, 2'b10, 0, 20, 0, 0, 0, 1);
    beat(1, 2'b10, 0, 30, 0, 0, 0, 1);
    rst = 1;
    beat(1, 2'b10, 0, 9, 9, 0, 0, 1);
    rst = 0;
    check("t6_valid", {31'b0, o_valid_s}, 32'sd0);
    beat(1, 2'b10, 0, 5, 0, 0, 0, 1);
    check("t6_restart", $signed(o_s[7:0]), 5);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      beat($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 3) != 0);
    end
    rst = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
